// File: rtl/vscale_imm_arbiter.sv
// Purpose : shares one combinational immediate generator between two requesters
//           (port 0 = decode pipeline, port 1 = debug/auxiliary) and registers
//           the generated immediate in a single-entry response slot.
// Latency : 1 cycle from accepted request to resp_valid/resp_imm/resp_id.
// Backpressure: req0_ready/req1_ready drop while the slot is FULL and resp_ready
//           is low. A FULL slot that drains in a cycle can be refilled in that
//           same cycle, which gives one response per cycle.
// Ports   : clk, reset_n (synchronous, active-low)
//           req0_* / req1_* : valid/ready request with inst and imm_type
//           gen_inst, gen_imm_type -> shared generator; gen_imm <- its result
//           resp_valid/resp_ready handshake carrying resp_imm and resp_id
// Config  : define VSCALE_IMM_ARB_RR_EN for round-robin arbitration.
//           When it is undefined, port 0 has fixed priority.
module vscale_imm_arbiter #(
    parameter int XPR_LEN        = 32,
    parameter int IMM_TYPE_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,

    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [XPR_LEN-1:0]        req0_inst,
    input  logic [IMM_TYPE_WIDTH-1:0] req0_imm_type,

    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [XPR_LEN-1:0]        req1_inst,
    input  logic [IMM_TYPE_WIDTH-1:0] req1_imm_type,

    output logic [XPR_LEN-1:0]        gen_inst,
    output logic [IMM_TYPE_WIDTH-1:0] gen_imm_type,
    input  logic [XPR_LEN-1:0]        gen_imm,

    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [XPR_LEN-1:0]        resp_imm,
    output logic                      resp_id
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state_q;
    logic [XPR_LEN-1:0]   resp_imm_q;
    logic                 resp_id_q;

    logic                 slot_free;
    logic                 any_req;
    logic                 accept;
    logic                 pick1;

    // The slot can take a new entry when it is empty. It can also take one
    // when its current entry leaves this cycle.
    assign slot_free = (state_q == EMPTY) || resp_ready;
    assign any_req   = req0_valid || req1_valid;
    // A request is never accepted during a reset cycle.
    assign accept    = reset_n && slot_free && any_req;

`ifdef VSCALE_IMM_ARB_RR_EN
    logic last_grant_q;

    // Under contention, the port that did not win last time wins now.
    assign pick1 = req1_valid && (!req0_valid || !last_grant_q);
`else
    // Fixed priority: port 1 wins only when port 0 is idle.
    assign pick1 = req1_valid && !req0_valid;
`endif

    // Ready is derived from valid, state, resp_ready and arbitration state
    // only. It never depends on gen_imm.
    assign req0_ready = accept && !pick1;
    assign req1_ready = accept &&  pick1;

    // Port 0 fields are the default selection when nothing is granted.
    assign gen_inst     = req1_ready ? req1_inst     : req0_inst;
    assign gen_imm_type = req1_ready ? req1_imm_type : req0_imm_type;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // Any held response is discarded without a handshake.
            state_q    <= EMPTY;
            resp_imm_q <= '0;
            resp_id_q  <= 1'b0;
`ifdef VSCALE_IMM_ARB_RR_EN
            // Treat port 1 as the last winner so that port 0 wins the
            // first contention after reset.
            last_grant_q <= 1'b1;
`endif
        end else if (accept) begin
            state_q    <= FULL;
            resp_imm_q <= gen_imm;
            resp_id_q  <= pick1;
`ifdef VSCALE_IMM_ARB_RR_EN
            last_grant_q <= pick1;
`endif
        end else if ((state_q == FULL) && resp_ready) begin
            state_q <= EMPTY;
        end
    end

    assign resp_valid = (state_q == FULL);
    assign resp_imm   = resp_imm_q;
    assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_vscale_imm_arbiter.sv
// Purpose : directed self-checking bench for vscale_imm_arbiter. It includes
//           a behavioural immediate generator that closes the gen_* loop.
// Latency : the bench checks the 1-cycle request-to-response latency.
// Backpressure: the bench drives resp_ready low to hold the slot and checks
//           that the slot stalls and then refills in the same cycle.
module tb_vscale_imm_arbiter;

    localparam int XPR_LEN = 32;
    localparam int ITW     = 2;
    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_U = 2'd2;
    localparam logic [1:0] IMM_J = 2'd3;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               req0_valid, req1_valid;
    logic               req0_ready, req1_ready;
    logic [XPR_LEN-1:0] req0_inst, req1_inst;
    logic [ITW-1:0]     req0_imm_type, req1_imm_type;
    logic [XPR_LEN-1:0] gen_inst;
    logic [ITW-1:0]     gen_imm_type;
    logic [XPR_LEN-1:0] gen_imm;
    logic               resp_valid, resp_ready, resp_id;
    logic [XPR_LEN-1:0] resp_imm;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // RV32 immediate decoding, written independently of the DUT.
    function automatic logic [31:0] imm_model(input logic [31:0] i, input logic [1:0] t);
        case (t)
            IMM_S:   imm_model = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_U:   imm_model = {i[31:12], 12'b0};
            IMM_J:   imm_model = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default: imm_model = {{20{i[31]}}, i[31:20]};
        endcase
    endfunction

    assign gen_imm = imm_model(gen_inst, gen_imm_type);

    vscale_imm_arbiter #(.XPR_LEN(XPR_LEN), .IMM_TYPE_WIDTH(ITW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_inst(req0_inst), .req0_imm_type(req0_imm_type),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_inst(req1_inst), .req1_imm_type(req1_imm_type),
        .gen_inst(gen_inst), .gen_imm_type(gen_imm_type), .gen_imm(gen_imm),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_imm(resp_imm), .resp_id(resp_id)
    );

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_inst = '0; req1_inst = '0;
        req0_imm_type = IMM_I; req1_imm_type = IMM_I;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        resp_ready = 1'b1;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; resp_ready = 1'b1;
        req0_valid = 1'b1; req0_inst = 32'hFFF00093; req0_imm_type = IMM_I;
        req1_valid = 1'b1; req1_inst = 32'h12345037; req1_imm_type = IMM_U;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got r0=%b r1=%b want 0 0", req0_ready, req1_ready);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b want 0", resp_valid);
        end
        checks++;
        if (resp_imm !== 32'h0 || resp_id !== 1'b0) begin
            failures++;
            $display("FAIL reset_imm_id: got imm=%h id=%b want 00000000 0", resp_imm, resp_id);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0 || req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: got valid=%b r0rdy=%b want 0 0", resp_valid, req0_ready);
        end
        idle_inputs();
    endtask

    task automatic test_port0_only();
        do_reset();
        req0_valid = 1'b1; req0_inst = 32'hFFF00093; req0_imm_type = IMM_I;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL p0_grant: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        checks++;
        if (gen_inst !== 32'hFFF00093 || gen_imm_type !== IMM_I) begin
            failures++;
            $display("FAIL p0_gen_mux: got %h/%0d want fff00093/0", gen_inst, gen_imm_type);
        end
        tick();
        req0_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_imm !== 32'hFFFFFFFF || resp_id !== 1'b0) begin
            failures++;
            $display("FAIL p0_resp: got v=%b imm=%h id=%b want 1 ffffffff 0", resp_valid, resp_imm, resp_id);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL p0_drain_empty: got valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_port1_back_to_back();
        do_reset();
        req1_valid = 1'b1; req1_inst = 32'h12345037; req1_imm_type = IMM_U;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || gen_inst !== 32'h12345037) begin
            failures++;
            $display("FAIL p1_grant: got r0=%b r1=%b gen=%h want 0 1 12345037", req0_ready, req1_ready, gen_inst);
        end
        tick();
        req1_inst = 32'hFFDFF06F; req1_imm_type = IMM_J;
        checks++;
        if (resp_valid !== 1'b1 || resp_imm !== 32'h12345000 || resp_id !== 1'b1) begin
            failures++;
            $display("FAIL p1_resp_u: got v=%b imm=%h id=%b want 1 12345000 1", resp_valid, resp_imm, resp_id);
        end
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            failures++;
            $display("FAIL p1_refill_ready: got %b want 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_imm !== 32'hFFFFFFFC || resp_id !== 1'b1) begin
            failures++;
            $display("FAIL p1_resp_j: got v=%b imm=%h id=%b want 1 fffffffc 1", resp_valid, resp_imm, resp_id);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [3:0] exp_ids;
`ifdef VSCALE_IMM_ARB_RR_EN
        exp_ids = 4'b1010;  // bit i = expected winner in cycle i: 0,1,0,1
`else
        exp_ids = 4'b0000;
`endif
        do_reset();
        req0_valid = 1'b1; req0_inst = 32'hFFF00093; req0_imm_type = IMM_I;
        req1_valid = 1'b1; req1_inst = 32'h12345037; req1_imm_type = IMM_U;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (req0_ready !== !exp_ids[i] || req1_ready !== exp_ids[i]) begin
                failures++;
                $display("FAIL contend_ready[%0d]: got r0=%b r1=%b want %b %b",
                         i, req0_ready, req1_ready, !exp_ids[i], exp_ids[i]);
            end
            tick();
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== exp_ids[i] ||
                resp_imm !== (exp_ids[i] ? 32'h12345000 : 32'hFFFFFFFF)) begin
                failures++;
                $display("FAIL contend_resp[%0d]: got v=%b id=%b imm=%h want id %b",
                         i, resp_valid, resp_id, resp_imm, exp_ids[i]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        req0_valid = 1'b1; req0_inst = 32'h00112623; req0_imm_type = IMM_S;
        tick();
        resp_ready = 1'b0;
        req0_inst = 32'hFFF00093; req0_imm_type = IMM_I;
        req1_valid = 1'b1; req1_inst = 32'h12345037; req1_imm_type = IMM_U;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready[%0d]: got r0=%b r1=%b want 0 0", i, req0_ready, req1_ready);
            end
            checks++;
            if (resp_valid !== 1'b1 || resp_imm !== 32'h0000000C || resp_id !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got v=%b imm=%h id=%b want 1 0000000c 0", i, resp_valid, resp_imm, resp_id);
            end
            tick();
        end
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready: got %b want 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_imm !== 32'hFFFFFFFF || resp_id !== 1'b0) begin
            failures++;
            $display("FAIL bp_refill: got v=%b imm=%h id=%b want 1 ffffffff 0", resp_valid, resp_imm, resp_id);
        end
        tick();
    endtask

    task automatic test_reset_while_full();
        do_reset();
        req0_valid = 1'b1; req0_inst = 32'h00112623; req0_imm_type = IMM_S;
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_imm !== 32'h0000000C) begin
            failures++;
            $display("FAIL rf_fill: got v=%b imm=%h want 1 0000000c", resp_valid, resp_imm);
        end
        resp_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL rf_ready_in_reset: got r0=%b r1=%b want 0 0", req0_ready, req1_ready);
        end
        tick();
        reset_n = 1'b1;
        req0_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || resp_imm !== 32'h0 || resp_id !== 1'b0) begin
            failures++;
            $display("FAIL rf_discard: got v=%b imm=%h id=%b want 0 00000000 0", resp_valid, resp_imm, resp_id);
        end
        resp_ready = 1'b1;
        tick();
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        resp_ready = 1'b1;
        tick();
        test_reset();
        test_port0_only();
        test_port1_back_to_back();
        test_contention();
        test_backpressure();
        test_reset_while_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vscale_imm_arbiter.md
VSCALE_IMM_ARBITER -- requirements
Module: vscale_imm_arbiter

Interface
REQ-001 clk  input  1  Single clock; all state updates on rising edge.
REQ-002 reset_n  input  1  Synchronous, active-low reset, sampled on rising edge of clk.
REQ-003 req0_valid  input  1  Port 0 (decode pipeline) request valid.
REQ-004 req0_ready  output  1  Port 0 request accepted this cycle when high with req0_valid.
REQ-005 req0_inst  input  XPR_LEN  Port 0 instruction word.
REQ-006 req0_imm_type  input  IMM_TYPE_WIDTH  Port 0 immediate format (IMM_I/IMM_S/IMM_U/IMM_J).
REQ-007 req1_valid, req1_ready, req1_inst, req1_imm_type  same as port 0  Port 1 (debug/auxiliary) request.
REQ-008 gen_inst  output  XPR_LEN  Instruction driven to the shared immediate generator.
REQ-009 gen_imm_type  output  IMM_TYPE_WIDTH  Format driven to the shared immediate generator.
REQ-010 gen_imm  input  XPR_LEN  Combinational immediate returned by the generator.
REQ-011 resp_valid  output  1  Response register holds a valid immediate.
REQ-012 resp_ready  input  1  Consumer accepts response when high with resp_valid.
REQ-013 resp_imm  output  XPR_LEN  Registered immediate.
REQ-014 resp_id  output  1  Port that issued the response (0 or 1).

Function
REQ-015 The block SHALL hold one output register with states EMPTY (resp_valid=0) and FULL (resp_valid=1).
REQ-016 Slot free = EMPTY, or FULL with resp_ready=1 (same-cycle drain and refill permitted).
REQ-017 When slot free and at least one reqN_valid, exactly one port SHALL be granted; reqN_ready=1 for the granted port only.
REQ-018 When slot not free, req0_ready=0 and req1_ready=0.
REQ-019 reqN_ready SHALL depend combinationally on reqN_valid, state, resp_ready and arbitration state only, never on gen_imm.
REQ-020 gen_inst/gen_imm_type SHALL mux the granted port's fields; with no grant, port 0 fields.
REQ-021 On grant in cycle N, resp_imm=gen_imm, resp_id=granted port and resp_valid=1 from cycle N+1 (latency 1).
REQ-022 FULL with resp_ready=0: resp_imm, resp_id, resp_valid SHALL hold unchanged.
REQ-023 FULL with resp_ready=1 and no request: transition to EMPTY next cycle.
REQ-024 Throughput: one response per cycle while resp_ready stays high and requests are present.
REQ-025 Requesters SHALL keep inst/imm_type stable while valid and not ready; arbiter SHALL NOT require it after acceptance.
REQ-026 Unknown imm_type codes SHALL pass through unchanged; the generator's default (I-type) applies.

Reset
REQ-027 reset_n=0 at a rising edge: state EMPTY, resp_valid=0, resp_imm=0, resp_id=0, arbitration pointer favours port 0.
REQ-028 During reset cycles req0_ready=0 and req1_ready=0; no request is accepted.
REQ-029 Reset asserted while FULL SHALL discard the held response without a handshake.

Configuration
REQ-030 Macro VSCALE_IMM_ARB_RR_EN defined: round-robin; 1-bit last_grant register, a contending port that did not win last time wins; updates only on an accepted grant.
REQ-031 Macro undefined: fixed priority, port 0 always wins contention; no last_grant register.

Verification
REQ-032 Port 0 only, inst=0xFFF00093, IMM_I, resp_ready=1 -> next cycle resp_valid=1, resp_imm=0xFFFFFFFF, resp_id=0.
REQ-033 Port 1 only, inst=0x12345037, IMM_U -> resp_imm=0x12345000, resp_id=1; then inst=0xFFDFF06F, IMM_J -> resp_imm=0xFFFFFFFC.
REQ-034 Both valid 4 cycles, resp_ready=1 -> RR build: resp_id 0,1,0,1; fixed build: 0,0,0,0 with req1_ready=0 throughout.
REQ-035 Grant inst=0x00112623 IMM_S, hold resp_ready=0 3 cycles -> resp_imm=0x0000000C stable, both ready=0; release -> drain and refill same cycle.
REQ-036 reset_n=0 for 1 cycle while FULL -> next cycle resp_valid=0, resp_imm=0, req ready low during reset.
